mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Iterative RV32M multiply/divide unit with its control FSM. It re-enables the FUNCT7_MUL decode path.
- Sits in the execute stage beside the ALU. It accepts an operation when the decoder issues ALUOP_MUL, and stalls the pipeline for the duration of the operation.
- Returns a single-cycle done pulse with the result, which then travels down the normal RESULT_ALU writeback path.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  execute-stage instruction is an M-extension op. Level signal, held while stalled.
- funct3  input  3  op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  input  XLEN  rs1 value (forwarded).
- op_b  input  XLEN  rs2 value (forwarded).
- flush  input  1  pipeline flush (trap/mispredict); aborts any operation.
- stall  output  1  hold the execute stage and everything upstream.
- busy  output  1  FSM not in IDLE.
- done  output  1  result valid this cycle; one-cycle pulse.
- result  output  XLEN  operation result; valid only while done=1.

Behaviour:
- Reset: state=IDLE, counter=0, all internal registers 0. Outputs stall=0, busy=0, done=0, result=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0: latch funct3 and operands, compute operand signs and magnitudes, and set the counter to XLEN.
  - Go to DONE directly for the fast-path cases below; otherwise go to CALC.
- CALC:
  - Perform one radix-2 step per cycle and decrement the counter.
  - Counter reaching 0 on this edge: go to DONE.
- DONE: done=1; result = the final result register. Next state is IDLE unconditionally.
- start is sampled only in IDLE. start still high in DONE is not a new request; the instruction leaves execute that cycle.
- stall = (state==IDLE & start & ~flush) | (state==CALC). stall=0 in DONE.
- busy = (state!=IDLE).
- Latency: start seen in IDLE at edge 0 → done=1 in the cycle after edge XLEN+1, i.e. 33 cycles of stall then the done cycle.
- Fast path: done=1 in the cycle after edge 1 (one stall cycle). Applies to:
  - divide by zero (op_b==0) for ops 4–7;
  - signed overflow (op_a==0x80000000, op_b==0xFFFFFFFF) for DIV/REM.
- Multiply: unsigned shift-add on magnitudes with a 2×XLEN product.
  - Signedness: MULH has both operands signed; MULHSU has op_a signed and op_b unsigned; MULHU and MUL are unsigned (MUL uses the low word, so sign is irrelevant).
  - Negate the 2×XLEN product if the effective operand signs differ.
  - MUL returns product[XLEN-1:0]; the MULH variants return product[2XLEN-1:XLEN].
- Divide: restoring division on magnitudes.
  - DIV/REM: operands signed. Quotient is negated if the signs differ; remainder takes the sign of the dividend.
  - DIVU/REMU: operands unsigned.
- Special results:
  - x/0: quotient = all ones; remainder = op_a.
  - Overflow: quotient = 0x80000000; remainder = 0.
- Flush has priority over everything. In any state the next state is IDLE, no done is asserted, and the counter is cleared.
- flush together with start in IDLE: the request is ignored and stall=0.
- Asynchronous reset mid-operation: return to IDLE immediately, outputs take their reset values, no done.
- Operands are latched at acceptance. Changes on op_a/op_b during CALC have no effect.

Test Plan:
- MUL op_a=7, op_b=0xFFFFFFFD (-3) → stall high 33 cycles, then done=1 for one cycle with result=0xFFFFFFEB; busy=0 afterwards.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each done 34 cycles after start.
- Fast path:
  - DIVU 0x1234/0 → 0xFFFFFFFF; REMU 0x1234/0 → 0x1234.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
  - Each with done in the second cycle and only one stall cycle.
- Flush and reset:
  - flush at CALC cycle 10 → IDLE next edge, no done pulse. A following DIVU 9/3 gives result 3 with full latency.
  - flush together with start in IDLE → stall=0 and no operation.
- rst_n low mid-CALC → busy, stall, and done drop to 0 immediately. After release with start held high, a fresh operation starts and completes correctly.

Source files
------------

// File: rtl/mdu_sequencer.sv
`timescale 1ns/1ps
// mdu_sequencer: iterative RV32M multiply/divide unit for the execute stage.
// A request is taken from IDLE when start is high and flush is low. The
// operation then runs one radix-2 step per cycle in CALC, while holding stall
// high. Divide-by-zero and signed overflow skip CALC entirely. DONE presents
// the result for exactly one cycle.
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start           M-extension op in execute (level, held while stalled)
//   funct3          0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   op_a, op_b      rs1 / rs2 operand values
//   flush           pipeline flush, aborts any operation
//   stall           hold execute and upstream stages
//   busy            FSM not idle
//   done            one-cycle result-valid pulse
//   result          operation result, meaningful while done=1
module mdu_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int DW = 2 * XLEN;

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_CALC = 2'd1, ST_DONE = 2'd2} state_t;

  state_t            state_r, next_state_s;
  logic [2:0]        funct3_r;
  logic [XLEN-1:0]   opnd_r;     // multiplicand or divisor magnitude
  logic [DW-1:0]     acc_r;      // mul: {partial hi, multiplier}; div: {remainder, quotient}
  logic              q_neg_r, r_neg_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [XLEN-1:0]   result_r;

  logic              accept_s, is_div_s, signed_a_s, signed_b_s, neg_a_s, neg_b_s;
  logic              div_zero_s, ovf_s, fast_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s, fast_res_s, final_res_s;
  logic [XLEN:0]     mul_sum_s, div_diff_s;
  logic [DW-1:0]     step_next_s, prod_fix_s;

  // Decode the incoming request: signedness, magnitudes and fast-path detection.
  always_comb begin
    accept_s   = (state_r == ST_IDLE) & start & ~flush;
    is_div_s   = funct3[2];
    signed_a_s = (funct3 == 3'd1) | (funct3 == 3'd2) | (funct3 == 3'd4) | (funct3 == 3'd6);
    signed_b_s = (funct3 == 3'd1) | (funct3 == 3'd4) | (funct3 == 3'd6);
    neg_a_s    = signed_a_s & op_a[XLEN-1];
    neg_b_s    = signed_b_s & op_b[XLEN-1];
    mag_a_s    = neg_a_s ? ({XLEN{1'b0}} - op_a) : op_a;
    mag_b_s    = neg_b_s ? ({XLEN{1'b0}} - op_b) : op_b;
    div_zero_s = is_div_s & (op_b == {XLEN{1'b0}});
    // Overflow only exists for the signed divide ops (funct3 bit 0 clear).
    ovf_s      = is_div_s & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}})
                 & (op_b == {XLEN{1'b1}});
    fast_s     = div_zero_s | ovf_s;
    if (div_zero_s) begin
      fast_res_s = funct3[1] ? op_a : {XLEN{1'b1}};
    end else begin
      fast_res_s = funct3[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // One radix-2 step (shift-add multiply or restoring divide) and sign fix-up of its outcome.
  always_comb begin
    mul_sum_s  = {1'b0, acc_r[DW-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
    // Shifted partial remainder is acc_r[DW-1:XLEN-1]; a clear top bit means it fits.
    div_diff_s = acc_r[DW-1:XLEN-1] - {1'b0, opnd_r};
    if (funct3_r[2]) begin
      if (!div_diff_s[XLEN]) begin
        step_next_s = {div_diff_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b1};
      end else begin
        step_next_s = {acc_r[DW-2:0], 1'b0};
      end
    end else begin
      step_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
    end
    prod_fix_s = q_neg_r ? ({DW{1'b0}} - step_next_s) : step_next_s;
    if (!funct3_r[2]) begin
      final_res_s = (funct3_r == 3'd0) ? prod_fix_s[XLEN-1:0] : prod_fix_s[DW-1:XLEN];
    end else if (funct3_r[1]) begin
      final_res_s = r_neg_r ? ({XLEN{1'b0}} - step_next_s[DW-1:XLEN]) : step_next_s[DW-1:XLEN];
    end else begin
      final_res_s = q_neg_r ? ({XLEN{1'b0}} - step_next_s[XLEN-1:0]) : step_next_s[XLEN-1:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FSM next-state logic; flush returns to IDLE from any state.
  always_comb begin
    next_state_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_state_s = fast_s ? ST_DONE : ST_CALC;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush) begin
          next_state_s = ST_IDLE;
        end else if (cnt_r == CNT_W'(1)) begin
          next_state_s = ST_DONE;
        end else begin
          next_state_s = ST_CALC;
        end
      end
      ST_DONE: next_state_s = ST_IDLE;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs; stall is gated by rst_n so it reads 0 while reset is held.
  always_comb begin
    stall  = (accept_s & rst_n) | (state_r == ST_CALC);
    busy   = (state_r != ST_IDLE);
    done   = (state_r == ST_DONE) & ~flush;
    result = result_r;
  end

  // Datapath: latch the request, iterate, and capture the final result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_r <= 3'd0;
      opnd_r   <= {XLEN{1'b0}};
      acc_r    <= {DW{1'b0}};
      q_neg_r  <= 1'b0;
      r_neg_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      result_r <= {XLEN{1'b0}};
    end else if (flush) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      funct3_r <= funct3;
      cnt_r    <= CNT_W'(XLEN);
      q_neg_r  <= neg_a_s ^ neg_b_s;
      r_neg_r  <= neg_a_s;
      opnd_r   <= is_div_s ? mag_b_s : mag_a_s;
      acc_r    <= {{XLEN{1'b0}}, (is_div_s ? mag_a_s : mag_b_s)};
      if (fast_s) begin
        result_r <= fast_res_s;
      end else begin
        result_r <= result_r;
      end
    end else if (state_r == ST_CALC) begin
      acc_r <= step_next_s;
      cnt_r <= cnt_r - CNT_W'(1);
      if (cnt_r == CNT_W'(1)) begin
        result_r <= final_res_s;
      end else begin
        result_r <= result_r;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
`timescale 1ns/1ps
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        stall, busy, done;
  logic [31:0] result;

  int vectors = 0;
  int errors  = 0;

  // Reference model state: an operation in flight and the cycles left before its result.
  bit          m_active = 1'b0;
  int          m_left   = 0;
  logic [31:0] m_res    = 32'd0;

  mdu_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Architectural RV32M result computed with plain 64-bit arithmetic.
  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'sd0;
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      3'd7: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Model update: accept in idle, then count down to the result cycle; flush/reset abort.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_left   <= 0;
    end else if (flush) begin
      m_active <= 1'b0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_res    <= ref_res(funct3, op_a, op_b);
        m_left   <= is_fast(funct3, op_a, op_b) ? 0 : 32;
      end
    end else if (m_left == 0) begin
      m_active <= 1'b0;
    end else begin
      m_left <= m_left - 1;
    end
  end

  // Compare process: every cycle, check stall/busy/done (and result when it is meaningful).
  always @(negedge clk) begin
    logic e_stall, e_busy, e_done;
    e_stall = rst_n && ((!m_active && start && !flush) || (m_active && m_left > 0));
    e_busy  = rst_n && m_active;
    e_done  = rst_n && m_active && (m_left == 0) && !flush;
    check("stall", {31'd0, stall}, {31'd0, e_stall});
    check("busy",  {31'd0, busy},  {31'd0, e_busy});
    check("done",  {31'd0, done},  {31'd0, e_done});
    if (e_done) check("model_result", result, m_res);
    if (!rst_n) check("reset_result", result, 32'd0);
  end

  // Issue one op, scramble inputs while it runs, and check result, latency and stall count.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_cyc, input bit rel);
    int cyc = 0;
    int st  = 0;
    bit got = 1'b0;
    @(posedge clk); #1;
    if (rel) rst_n = 1'b1;
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    while (!got && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (stall) st++;
      if (done) begin
        got = 1'b1;
        check("op_result", result, exp);
        check("op_latency", cyc, exp_cyc);
        check("op_stall_cycles", st, exp_cyc - 1);
      end else begin
        @(posedge clk); #1;
        op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom_range(0, 7));
      end
    end
    if (!got) begin
      vectors++;
      errors++;
      $display("FAIL done_timeout: no done within %0d cycles, expected at cycle %0d", cyc, exp_cyc);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Issue an op and flush it k edges after it is issued.
  task automatic abort_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int k);
    @(posedge clk); #1;
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    repeat (k) @(posedge clk);
    #1; flush = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_res",   result,         32'd0);

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 1'b1);
    @(negedge clk);
    check("mul_busy_after", {31'd0, busy}, 32'd0);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 34, 1'b0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 1'b0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 1'b0);
    run_op(3'd5, 32'd100,       32'd7,         32'd14,        34, 1'b0);
    run_op(3'd7, 32'd100,       32'd7,         32'd2,         34, 1'b0);
    run_op(3'd5, 32'h1234,      32'd0,         32'hFFFF_FFFF, 2,  1'b0);
    run_op(3'd7, 32'h1234,      32'd0,         32'h1234,      2,  1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2,  1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2,  1'b0);

    // Flush around CALC cycle 10, then a full-latency DIVU.
    abort_op(3'd5, 32'd99, 32'd5, 11);
    @(negedge clk);
    check("flush_busy", {31'd0, busy}, 32'd0);
    repeat (40) @(negedge clk);
    run_op(3'd5, 32'd9, 32'd3, 32'd3, 34, 1'b0);

    // flush together with start in IDLE: no stall, no operation.
    @(posedge clk); #1;
    funct3 = 3'd4; op_a = 32'd50; op_b = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_start_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-CALC, then a fresh op with start held through reset.
    @(posedge clk); #1;
    funct3 = 3'd3; op_a = $urandom; op_b = $urandom; start = 1'b1;
    repeat (15) @(posedge clk);
    #1; rst_n = 1'b0; funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7;
    #1;
    check("midrst_busy",  {31'd0, busy},  32'd0);
    check("midrst_stall", {31'd0, stall}, 32'd0);
    check("midrst_done",  {31'd0, done},  32'd0);
    repeat (2) @(posedge clk);
    run_op(3'd5, 32'd100, 32'd7, 32'd14, 34, 1'b1);

    // Randomized ops with biased corner operands and occasional aborts.
    for (int i = 0; i < 60; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 200); b = $urandom_range(1, 20); end
        3: begin a = -$urandom_range(0, 200); b = -$urandom_range(1, 20); end
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) begin
        abort_op(f, a, b, $urandom_range(1, 33));
      end else begin
        run_op(f, a, b, ref_res(f, a, b), is_fast(f, a, b) ? 2 : 34, 1'b0);
      end
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
